sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the project FIFO.
//  Adds configurable width/depth, full/empty/almost flags, an occupancy count,
//  sticky overflow/underflow errors and a selectable first-word-fall-through read mode.
//  Intended as the buffering primitive between streaming producer/consumer blocks on the Arty-7 fabric.
// PARAMETERS
//  DATA_WIDTH   8   width of each stored word
//  DEPTH        16  number of entries, any integer >= 2 (power of two not required)
//  AF_LEVEL     12  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL     2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT         0   0 = registered read (1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk           in   1                  single clock, all logic on rising edge
//  rst           in   1                  synchronous, active-high reset
//  wr_en         in   1                  write request
//  wr_data       in   DATA_WIDTH         word to write
//  rd_en         in   1                  read/pop request
//  rd_data       out  DATA_WIDTH         read word
//  rd_valid      out  1                  rd_data holds a valid word (see BEHAVIOUR)
//  full          out  1                  count == DEPTH
//  empty         out  1                  count == 0
//  almost_full   out  1                  count >= AF_LEVEL
//  almost_empty  out  1                  count <= AE_LEVEL
//  count         out  $clog2(DEPTH+1)    current occupancy
//  overflow      out  1                  sticky: write attempted and rejected
//  underflow     out  1                  sticky: read attempted while empty
//  clr_err       in   1                  clears overflow/underflow
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0,
//   rd_data=0, rd_valid=0, overflow=underflow=0. Storage array not cleared. rst overrides
//   every other input; wr_en/rd_en in a reset cycle have no effect (also mid-operation).
//  rd_acc = rd_en & ~empty.  wr_acc = wr_en & (~full | rd_acc).
//  Simultaneous accepted read+write: count unchanged; legal when full (slot freed same cycle).
//  Empty with wr_en&rd_en: write accepted, read rejected (underflow set); no bypass.
//  Pointers advance by 1 on accept, wrap DEPTH-1 -> 0. count +1 on write-only, -1 on read-only.
//  count and all four flags are registered and updated together from next-state count, so
//   flags are always consistent with count in the same cycle.
//  FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle; rd_valid is a
//   1-cycle pulse per accepted read; rd_data holds its last value otherwise.
//  FWFT=1: rd_data = mem[rd_ptr] (combinational read of head), rd_valid = ~empty;
//   rd_en pops the displayed word; rd_data undefined (don't care) while empty.
//  A word written in cycle N is readable no earlier than cycle N+1 (empty deasserts at N+1).
//  overflow <= 1 when wr_en & ~wr_acc; underflow <= 1 when rd_en & empty.
//  Sticky until rst or clr_err; if a new error event coincides with clr_err, set wins.
//  Rejected operations never alter pointers, count or storage.
// TESTING
//  1 Reset then rd_en=1 for 1 cycle -> underflow=1, empty=1, count=0, rd_valid stays 0.
//  2 FWFT=0: write 7 then 8, then rd_en 2 cycles -> rd_valid pulses carry 7 then 8, empty=1 after.
//  3 DEPTH=16: write 9..24 continuously -> full=1 at count=16, almost_full from count=12;
//    17th write (25) -> overflow=1, count stays 16, later reads return 9..24 in order.
//  4 Full, wr_en&rd_en for 3 cycles with 30,31,32 -> count stays 16, overflow stays 0,
//    reads 9,10,11; draining yields 12..24,30,31,32 (checks pointer wrap).
//  5 DEPTH=5, FWFT=1: write 1..5, pop 3, write 6..8 -> rd_data shows 4 immediately,
//    pop order 4,5,6,7,8 (non-power-of-two wrap); rd_valid=0 once empty.
//  6 count=6 mid-stream, assert rst with wr_en&rd_en=1 -> next cycle count=0, empty=1,
//    errors cleared; clr_err with concurrent rejected write -> overflow remains 1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with flags, count, sticky errors and optional FWFT read
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rd_acc, wr_acc;
  logic [CW-1:0] cnt_nxt;
  always_comb begin
    rd_acc  = rd_en & ~empty;
    wr_acc  = wr_en & (~full | rd_acc);
    cnt_nxt = (wr_acc & ~rd_acc) ? count + 1'b1 : (rd_acc & ~wr_acc) ? count - 1'b1 : count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count        <= cnt_nxt;
      full         <= cnt_nxt == CW'(DEPTH);
      empty        <= cnt_nxt == '0;
      almost_full  <= cnt_nxt >= CW'(AF_LEVEL);
      almost_empty <= cnt_nxt <= CW'(AE_LEVEL);
      overflow     <= (wr_en & ~wr_acc) | (overflow & ~clr_err);
      underflow    <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end
  always_ff @(posedge clk)
    if (wr_acc & ~rst) mem[wr_ptr] <= wr_data;
  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        if (rd_acc) rd_data <= mem[rd_ptr];
        rd_valid <= rd_acc;
      end
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for a registered-read DEPTH=16 and an FWFT DEPTH=5 FIFO
module tb_sync_fifo_param;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int n_run = 0, n_fail = 0;
  logic       wr_en0 = 0, rd_en0 = 0, clr0 = 0;
  logic [7:0] wr_data0 = 0, rd_data0;
  logic       rd_valid0, full0, empty0, af0, ae0, ov0, un0;
  logic [4:0] count0;
  logic       wr_en1 = 0, rd_en1 = 0, clr1 = 0;
  logic [7:0] wr_data1 = 0, rd_data1;
  logic       rd_valid1, full1, empty1, af1, ae1, ov1, un1;
  logic [2:0] count1;
  logic [7:0] q0[$], q1[$];
  bit m_ov0 = 0, m_un0 = 0, m_ov1 = 0, m_un1 = 0;
  sync_fifo_param u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ov0),
    .underflow(un0), .clr_err(clr0)
  );
  sync_fifo_param #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ov1),
    .underflow(un1), .clr_err(clr1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op0(input bit we, input logic [7:0] wd, input bit re, input bit ce = 0);
    logic [7:0] e;
    bit ra, wa;
    wr_en0 = we; wr_data0 = wd; rd_en0 = re; clr0 = ce;
    ra = re && q0.size() != 0;
    wa = we && (q0.size() != 16 || ra);
    e = 0;
    if (ra) e = q0.pop_front();
    if (wa) q0.push_back(wd);
    if (ce) begin m_ov0 = 0; m_un0 = 0; end
    if (we && !wa) m_ov0 = 1;
    if (re && !ra) m_un0 = 1;
    tick();
    wr_en0 = 0; rd_en0 = 0; clr0 = 0;
    chk("u0 count", count0, q0.size());
    chk("u0 full", full0, q0.size() == 16);
    chk("u0 empty", empty0, q0.size() == 0);
    chk("u0 almost_full", af0, q0.size() >= 12);
    chk("u0 almost_empty", ae0, q0.size() <= 2);
    chk("u0 rd_valid", rd_valid0, ra);
    if (ra) chk("u0 rd_data", rd_data0, e);
    chk("u0 overflow", ov0, m_ov0);
    chk("u0 underflow", un0, m_un0);
  endtask
  task automatic op1(input bit we, input logic [7:0] wd, input bit re);
    bit ra, wa;
    wr_en1 = we; wr_data1 = wd; rd_en1 = re;
    ra = re && q1.size() != 0;
    wa = we && (q1.size() != 5 || ra);
    if (ra) void'(q1.pop_front());
    if (wa) q1.push_back(wd);
    if (we && !wa) m_ov1 = 1;
    if (re && !ra) m_un1 = 1;
    tick();
    wr_en1 = 0; rd_en1 = 0;
    chk("u1 count", count1, q1.size());
    chk("u1 full", full1, q1.size() == 5);
    chk("u1 empty", empty1, q1.size() == 0);
    chk("u1 almost_full", af1, q1.size() >= 4);
    chk("u1 almost_empty", ae1, q1.size() <= 1);
    chk("u1 rd_valid", rd_valid1, q1.size() != 0);
    if (q1.size() != 0) chk("u1 head", rd_data1, q1[0]);
    chk("u1 overflow", ov1, m_ov1);
    chk("u1 underflow", un1, m_un1);
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    chk("rst count", count0, 0);
    chk("rst empty", empty0, 1);
    chk("rst almost_empty", ae0, 1);
    chk("rst full", full0, 0);
    chk("rst almost_full", af0, 0);
    chk("rst rd_valid", rd_valid0, 0);
    chk("rst rd_data", rd_data0, 0);
    chk("rst overflow", ov0, 0);
    chk("rst u1 rd_valid", rd_valid1, 0);
    op0(0, 0, 1);
    chk("t1 underflow", un0, 1);
    op0(0, 0, 0, 1);
    op0(1, 7, 0);
    op0(1, 8, 0);
    op0(0, 0, 1);
    chk("t2 first", rd_data0, 7);
    op0(0, 0, 1);
    chk("t2 second", rd_data0, 8);
    chk("t2 empty", empty0, 1);
    op0(0, 0, 0);
    chk("t2 rd_valid pulse", rd_valid0, 0);
    chk("t2 rd_data hold", rd_data0, 8);
    for (int i = 9; i <= 24; i++) begin
      op0(1, 8'(i), 0);
      if (i == 20) chk("t3 af at 12", af0, 1);
    end
    chk("t3 full", full0, 1);
    op0(1, 25, 0);
    chk("t3 overflow", ov0, 1);
    chk("t3 count held", count0, 16);
    op0(0, 0, 0, 1);
    chk("t4 ov cleared", ov0, 0);
    for (int i = 0; i < 3; i++) op0(1, 8'(30 + i), 1);
    chk("t4 third read", rd_data0, 11);
    chk("t4 no overflow", ov0, 0);
    for (int i = 0; i < 16; i++) op0(0, 0, 1);
    chk("t4 last drained", rd_data0, 32);
    for (int i = 0; i < 6; i++) op0(1, 8'(40 + i), 0);
    op0(0, 0, 1);
    op0(1, 50, 0);
    chk("t6 count 6", count0, 6);
    wr_en0 = 1; rd_en0 = 1; wr_data0 = 77; rst = 1;
    q0.delete(); m_ov0 = 0; m_un0 = 0;
    tick();
    rst = 0; wr_en0 = 0; rd_en0 = 0;
    chk("t6 count", count0, 0);
    chk("t6 empty", empty0, 1);
    chk("t6 overflow", ov0, 0);
    chk("t6 underflow", un0, 0);
    chk("t6 rd_valid", rd_valid0, 0);
    op0(0, 0, 0);
    for (int i = 0; i < 16; i++) op0(1, 8'(100 + i), 0);
    op0(1, 1, 0);
    op0(1, 2, 0, 1);
    chk("t6 set wins", ov0, 1);
    op0(0, 0, 0, 1);
    chk("t6 cleared", ov0, 0);
    for (int i = 1; i <= 5; i++) op1(1, 8'(i), 0);
    chk("t5 full", full1, 1);
    for (int i = 0; i < 3; i++) op1(0, 0, 1);
    chk("t5 head 4", rd_data1, 4);
    for (int i = 6; i <= 8; i++) op1(1, 8'(i), 0);
    for (int i = 4; i <= 8; i++) begin
      chk("t5 pop order", rd_data1, i);
      op1(0, 0, 1);
    end
    chk("t5 rd_valid empty", rd_valid1, 0);
    op1(0, 0, 1);
    chk("t5 underflow", un1, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
